// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiply / restoring divide accumulator with final sign correction.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       funct_3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_next
);

    // {remainder, quotient} for divides, {high, low} product for multiplies
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic [2:0]         op_r;
    logic               neg_r;
    logic               div0_r;

    logic               sa_s, sb_s, neg_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s, rem_sh_s, diff_s;
    logic               take_s;
    logic [2*WIDTH-1:0] acc_nxt_s, prod_neg_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic n, input logic [WIDTH-1:0] v);
        cond_neg = n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand magnitudes and result sign captured at accept
    always_comb begin
        sa_s    = (funct_3 == F_MULH) || (funct_3 == F_MULHSU) || (funct_3 == F_DIV) || (funct_3 == F_REM);
        sb_s    = (funct_3 == F_MULH) || (funct_3 == F_DIV) || (funct_3 == F_REM);
        mag_a_s = cond_neg(sa_s && src_a[WIDTH-1], src_a);
        mag_b_s = cond_neg(sb_s && src_b[WIDTH-1], src_b);
        case (funct_3)
            F_MULH:   neg_s = src_a[WIDTH-1] ^ src_b[WIDTH-1];
            F_MULHSU: neg_s = src_a[WIDTH-1];
            F_DIV:    neg_s = src_a[WIDTH-1] ^ src_b[WIDTH-1];
            F_REM:    neg_s = src_a[WIDTH-1];
            default:  neg_s = 1'b0;
        endcase
    end

    // One iteration; a zero divisor never subtracts so the remainder collects the dividend
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
        rem_sh_s  = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s    = rem_sh_s - {1'b0, opb_r};
        take_s    = (opb_r != {WIDTH{1'b0}}) && !diff_s[WIDTH];
        if (op_r[2]) begin
            acc_nxt_s = {(take_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0]), acc_r[WIDTH-2:0], take_s};
        end else if (acc_r[0]) begin
            acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else begin
            acc_nxt_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end
    end

    // Result selection from the post-step accumulator
    always_comb begin
        prod_neg_s = ~acc_nxt_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        case (op_r)
            F_MUL:                     result_next = acc_nxt_s[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU: result_next = neg_r ? prod_neg_s[2*WIDTH-1:WIDTH] : acc_nxt_s[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:             result_next = div0_r ? {WIDTH{1'b1}} : cond_neg(neg_r, acc_nxt_s[WIDTH-1:0]);
            F_REM, F_REMU:             result_next = cond_neg(neg_r, acc_nxt_s[2*WIDTH-1:WIDTH]);
            default:                   result_next = {WIDTH{1'b0}};
        endcase
    end

    // Accumulator and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r  <= {(2*WIDTH){1'b0}};
            opb_r  <= {WIDTH{1'b0}};
            op_r   <= 3'b000;
            neg_r  <= 1'b0;
            div0_r <= 1'b0;
        end else if (load) begin
            acc_r  <= {{WIDTH{1'b0}}, mag_a_s};
            opb_r  <= mag_b_s;
            op_r   <= funct_3;
            neg_r  <= neg_s;
            div0_r <= (src_b == {WIDTH{1'b0}});
        end else if (step) begin
            acc_r  <= acc_nxt_s;
        end else begin
            acc_r  <= acc_r;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide controller: IDLE/CALC/DONE FSM around muldiv_datapath.
// Optional MULDIV_EARLY_OUT_EN skips CALC for zero divisors and zero multiplicands.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct_3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             stall_e
);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             load_s, step_s, last_s, early_s;
    logic [WIDTH-1:0] result_next_s, early_res_s;

    assign load_s  = (state == S_IDLE) && start && !flush;
    assign step_s  = (state == S_CALC) && !flush;
    assign last_s  = (counter == CNT_W'(WIDTH-1));
    assign stall_e = ((state == S_IDLE) && start) || (state == S_CALC);

    // Early-out decision and its result, evaluated on the raw operands
    always_comb begin
        early_s     = 1'b0;
        early_res_s = {WIDTH{1'b0}};
`ifdef MULDIV_EARLY_OUT_EN
        early_s = (src_b == {WIDTH{1'b0}}) || (!funct_3[2] && (src_a == {WIDTH{1'b0}}));
        if (funct_3[2] && !funct_3[1]) begin
            early_res_s = {WIDTH{1'b1}};
        end else if (funct_3[2]) begin
            early_res_s = src_a;
        end else begin
            early_res_s = {WIDTH{1'b0}};
        end
`endif
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .step        (step_s),
        .funct_3     (funct_3),
        .src_a       (src_a),
        .src_b       (src_b),
        .result_next (result_next_s)
    );

    // Control FSM with registered result/done/busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= {CNT_W{1'b0}};
            result  <= {WIDTH{1'b0}};
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done    <= 1'b0;
                    counter <= {CNT_W{1'b0}};
                    if (load_s && early_s) begin
                        state  <= S_DONE;
                        result <= early_res_s;
                        done   <= 1'b1;
                        busy   <= 1'b1;
                    end else if (load_s) begin
                        state <= S_CALC;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (last_s) begin
                        state   <= S_DONE;
                        counter <= counter + {{(CNT_W-1){1'b0}}, 1'b1};
                        result  <= result_next_s;
                        done    <= 1'b1;
                    end else begin
                        counter <= counter + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct_3;
    logic [31:0] src_a, src_b, result;
    logic        done, busy, stall_e;

    int checks = 0;
    int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 33;
`endif

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct_3 (funct_3),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .stall_e (stall_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit stall_ok;
        @(negedge clk);
        start = 1'b1; funct_3 = f; src_a = a; src_b = b;
        #1;
        stall_ok = (stall_e === 1'b1);
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (stall_e !== 1'b1) stall_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " stall_in_done"}, {31'd0, stall_e}, 32'd0);
        check({tag, " stall_before_done"}, {31'd0, stall_ok}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct_3 = 3'b000; src_a = 32'd0; src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall_e", {31'd0, stall_e}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("MULHU ff*ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("MULH -1*-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("MULHSU -1*2", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        run_op("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, LAT_Z);
        run_op("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5, LAT_Z);
        run_op("REM -5/0", 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, LAT_Z);
        run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);

        // flush at cycle 10 of a DIV
        @(negedge clk);
        start = 1'b1; funct_3 = 3'b100; src_a = 32'd100; src_b = 32'd7;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush stall_e", {31'd0, stall_e}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("flush no done", 32'(dones), 32'd0);
        run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // reset at cycle 20 of a MUL
        @(negedge clk);
        start = 1'b1; funct_3 = 3'b000; src_a = 32'd5; src_b = 32'd6;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("midreset result", result, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset stall_e", {31'd0, stall_e}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("MUL 3*4 after reset", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // back-to-back: start held through DONE
        @(negedge clk);
        start = 1'b1; funct_3 = 3'b000; src_a = 32'd2; src_b = 32'd3;
        wait_done(lat);
        check("b2b first latency", 32'(lat), 32'd33);
        check("b2b first result", result, 32'd6);
        @(negedge clk);
        funct_3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
        #1;
        check("b2b stall in done", {31'd0, stall_e}, 32'd0);
        @(posedge clk); #1;
        check("b2b idle busy", {31'd0, busy}, 32'd0);
        check("b2b idle done", {31'd0, done}, 32'd0);
        check("b2b idle stall_e", {31'd0, stall_e}, 32'd1);
        wait_done(lat);
        check("b2b second latency", 32'(lat), 32'd33);
        check("b2b second result", result, 32'd14);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;

        run_op("DIVU 9/0", 3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, LAT_Z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own controller for the RV32M instructions in the EX stage.
- Accepts one operation from EX and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Holds the pipeline through a stall output until a one-cycle done pulse.
- Sits beside the main ALU. Its result is muxed into the EX result when the decoder flags an M-type op.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX holds a valid M-type op; held high by the pipeline until done.
- funct_3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  WIDTH  rs1 operand; sampled at accept.
- src_b  input  WIDTH  rs2 operand; sampled at accept.
- flush  input  1  FlushE from the hazard unit; aborts the operation.
- result  output  WIDTH  final result; valid only while done=1.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high in CALC and DONE.
- stall_e  output  1  stall request to the hazard unit.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, result=0, done=0, busy=0, counter=0, internal accumulators=0. Reset wins over every other input, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch funct_3.
  - Store operand magnitudes for signed ops (MULH/MULHSU: src_a signed, src_b unsigned for MULHSU; DIV/REM signed).
  - Latch result sign; counter=0; go to CALC.
- CALC: one iteration per cycle.
  - Multiply: 2*WIDTH-bit product register, add-then-shift-right.
  - Divide: restoring shift-subtract, quotient and remainder registers.
  - Counter increments. At counter==WIDTH-1, go to DONE.
- DONE:
  - done=1 and result driven, with sign correction applied.
  - MUL returns the low WIDTH bits; MULH* return the high WIDTH bits.
  - DIV* return the quotient; REM* return the remainder.
  - Return to IDLE next cycle regardless of start.
- Latency: accept at cycle 0 -> done at cycle WIDTH+1 (33 for WIDTH=32).
- stall_e = (state==IDLE & start) | (state==CALC). It is low in DONE so the pipeline advances and captures result that same edge.
- start is ignored outside IDLE. A new op can be accepted in the IDLE cycle following DONE.
- Divide by zero: quotient = all ones (DIVU 0xFFFFFFFF, DIV -1); remainder = src_a. This overrides sign correction.
- Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Remainder sign follows the dividend; quotient sign = sign(a) XOR sign(b).
- flush=1 in any state: next state IDLE, done stays 0, no result produced. flush in the same cycle as start blocks acceptance.
- result holds its last value outside DONE; the consumer must qualify it with done.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, an accepted op with src_b==0 (any op), or with src_a==0 on a multiply, skips CALC and goes straight to DONE. done arrives at cycle 1, stall_e is asserted only in the accept cycle, and result follows the divide-by-zero/zero-product rules above.
- Undefined: every op takes the full WIDTH+1 cycles; identical results.

Decomposition:
- Shared package muldiv_pkg:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
  - funct_3 opcode constants.
  - M-extension funct_7 value 7'b0000001, used by the control decoder to raise start.
- Natural sub-module: muldiv_datapath. It holds the product/quotient/remainder registers and the add/subtract step; its step, load and op-select inputs are driven by the FSM in muldiv_sequencer.

Test Plan:
- MUL 7 x -3 -> done at cycle 33, result 0xFFFFFFEB; stall_e high cycles 0-32, low at 33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- flush at cycle 10 of a DIV -> IDLE at cycle 11, no done pulse. reset at cycle 20 of a MUL -> all outputs 0 next cycle. Both followed by a fresh MUL 3 x 4 -> 12.
- Back-to-back: second start asserted in the DONE cycle is ignored and accepted in the following IDLE cycle. With MULDIV_EARLY_OUT_EN, DIVU 9 / 0 -> done at cycle 1, result 0xFFFFFFFF.
